// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA adder scheduler: FSM states,
// nibble width, requester count and the round-robin pick function.
package cla_pkg;

    localparam int NIBBLE_W = 4;
    localparam int NUM_REQ  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cla_state_e;

    // last_id is the requester served most recently; on a tie the other one wins.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic               last_id);
        logic [NUM_REQ-1:0] pick;
        pick = req;
        if (req[0] && req[1]) begin
            pick = last_id ? 2'b01 : 2'b10;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cla_4_bit.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
module cla_4_bit
    import cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                pg,
    output logic                gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign pg   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c[4] = gg | (pg & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_add_sched.sv
// Two-requester add scheduler: one shared 4-bit CLA walks the operands one nibble
// per cycle. Define CLA_SCHED_SUB_EN to add the per-requester subtract port.
module cla_add_sched
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
`ifdef CLA_SCHED_SUB_EN
    input  logic [NUM_REQ-1:0] sub,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]          state;
    logic [CNT_W-1:0]    nib_cnt;
    logic                carry;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                id_q;
    logic                last_id;

    logic                win_id;
    logic [WIDTH-1:0]    a_sel;
    logic [WIDTH-1:0]    b_sel;
    logic                cin_init;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_co;
    logic                cla_pg_unused;
    logic                cla_gg_unused;

    // Valid/ready: req is the requester's valid, gnt its ready; a transfer
    // happens on the edge at the end of any cycle where both are high.
    assign gnt       = (state == IDLE) ? rr_pick(req, last_id) : '0;
    assign win_id    = gnt[1];
    assign a_sel     = win_id ? a1 : a0;
    assign b_sel     = win_id ? b1 : b0;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    assign nib_a = a_q[int'(nib_cnt) * NIBBLE_W +: NIBBLE_W];

`ifdef CLA_SCHED_SUB_EN
    logic sub_q;

    // Subtract is a + ~b + 1: invert b per nibble and seed the carry with 1.
    assign cin_init = sub[win_id];
    assign nib_b    = sub_q ? ~b_q[int'(nib_cnt) * NIBBLE_W +: NIBBLE_W]
                            :  b_q[int'(nib_cnt) * NIBBLE_W +: NIBBLE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (gnt != '0) begin
            sub_q <= sub[win_id];
        end
    end
`else
    assign cin_init = 1'b0;
    assign nib_b    = b_q[int'(nib_cnt) * NIBBLE_W +: NIBBLE_W];
`endif

    cla_4_bit u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_co),
        .pg   (cla_pg_unused),
        .gg   (cla_gg_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            nib_cnt <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            last_id <= 1'b1;
            result  <= '0;
            cout    <= 1'b0;
            done    <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (gnt != '0) begin
                        a_q     <= a_sel;
                        b_q     <= b_sel;
                        id_q    <= win_id;
                        last_id <= win_id;
                        nib_cnt <= '0;
                        carry   <= cin_init;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result[int'(nib_cnt) * NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry   <= nib_co;
                    nib_cnt <= nib_cnt + 1'b1;
                    // The top nibble's carry is the operation's carry-out.
                    if (nib_cnt == CNT_W'(NIB - 1)) begin
                        cout       <= nib_co;
                        done[id_q] <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_add_sched.sv
// Self-checking bench for cla_add_sched: randomized requests against a
// cycle-level arbitration/latency model and plain-arithmetic sums.
module tb_cla_add_sched;
    import cla_pkg::*;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / NIBBLE_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] a0, b0, a1, b1;
`ifdef CLA_SCHED_SUB_EN
    logic [1:0]       sub;
`endif
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;
    logic [1:0]       state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit contention = 1'b0;

    // Reference model state
    int               m_next_free = 0;
    logic             m_last = 1'b1;
    logic [WIDTH-1:0] m_res = '0;
    logic             m_cout = 1'b0;
    logic [1:0]       prev_done = 2'b00;
    int               due_q[$];
    logic             due_id_q[$];
    logic [WIDTH:0]   exp_q[$];

    // Per-requester pending operations
    logic [WIDTH-1:0] qa0[$], qb0[$], qa1[$], qb1[$];

    cla_add_sched #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
`ifdef CLA_SCHED_SUB_EN
        .sub       (sub),
`endif
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [1:0]       exp_gnt;
        logic [1:0]       exp_done;
        logic [WIDTH:0]   want;
        logic [WIDTH-1:0] op_a, op_b;
        logic             w;
        if (rst) begin
            due_q.delete();
            due_id_q.delete();
            exp_q.delete();
            m_last      = 1'b1;
            m_next_free = 0;
            m_res       = '0;
            m_cout      = 1'b0;
            prev_done   = 2'b00;
            if (mon_en) begin
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 2'b00);
                check("rst_result", {cout, result}, '0);
            end
        end else if (mon_en) begin
            check("busy", busy, cyc < m_next_free);

            exp_done = 2'b00;
            if (due_q.size() > 0 && due_q[0] == cyc) exp_done = 2'b01 << due_id_q[0];
            check("done", done, exp_done);

            if (exp_done != 2'b00) begin
                void'(due_q.pop_front());
                void'(due_id_q.pop_front());
                want = exp_q.pop_front();
                check("sum", {cout, result}, want);
                m_res  = want[WIDTH-1:0];
                m_cout = want[WIDTH];
                if (contention && prev_done != 2'b00) check("alternate", done != prev_done, 1'b1);
                prev_done = exp_done;
            end else if (cyc >= m_next_free) begin
                check("held", {cout, result}, {m_cout, m_res});
            end

            exp_gnt = 2'b00;
            w = 1'b0;
            if (cyc >= m_next_free && req != 2'b00) begin
                w = (req == 2'b11) ? ~m_last : req[1];
                exp_gnt = 2'b01 << w;
            end
            check("gnt", gnt, exp_gnt);

            if (exp_gnt != 2'b00) begin
                op_a = w ? a1 : a0;
                op_b = w ? b1 : b0;
                want = {1'b0, op_a} + {1'b0, op_b};
`ifdef CLA_SCHED_SUB_EN
                if (sub[w]) want = {op_a >= op_b, op_a - op_b};
`endif
                due_q.push_back(cyc + NIB + 1);
                due_id_q.push_back(w);
                exp_q.push_back(want);
                m_last      = w;
                m_next_free = cyc + NIB + 2;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_ops(input int budget);
        int n = 0;
        logic [1:0] g;
        while ((qa0.size() > 0 || qa1.size() > 0) && n < budget) begin
            req[0] = (qa0.size() > 0);
            req[1] = (qa1.size() > 0);
            if (req[0]) begin a0 = qa0[0]; b0 = qb0[0]; end
            if (req[1]) begin a1 = qa1[0]; b1 = qb1[0]; end
            contention = (qa0.size() >= 2) && (qa1.size() >= 2);
            @(negedge clk);
            g = gnt;
            @(posedge clk); #1;
            if (g[0]) begin void'(qa0.pop_front()); void'(qb0.pop_front()); end
            if (g[1]) begin void'(qa1.pop_front()); void'(qb1.pop_front()); end
            n++;
        end
        req = 2'b00;
        contention = 1'b0;
        check("budget", n < budget, 1'b1);
        qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
        repeat (NIB + 3) @(posedge clk);
        #1;
    endtask

    task automatic push_op(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (id) begin qa1.push_back(a); qb1.push_back(b); end
        else    begin qa0.push_back(a); qb0.push_back(b); end
    endtask

    // Requester 1 appears during a busy period and withdraws before IDLE.
    task automatic withdraw_test();
        logic [1:0] g;
        req = 2'b01; a0 = 16'h0F0F; b0 = 16'h7070;
        @(negedge clk);
        g = gnt;
        check("wd_gnt0", g, 2'b01);
        @(posedge clk); #1;
        req = 2'b10; a1 = 16'hAAAA; b1 = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        req = 2'b00;
        repeat (NIB + 4) @(posedge clk);
        #1;
    endtask

    // Reset in the third RUN cycle aborts the operation without a done pulse.
    task automatic reset_mid_run();
        logic [1:0] g;
        req = 2'b01; a0 = 16'h4321; b0 = 16'h1234;
        @(negedge clk);
        g = gnt;
        check("ab_gnt0", g, 2'b01);
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("ab_state", state_dbg, ST_IDLE);
        check("ab_busy", busy, 1'b0);
        repeat (NIB + 4) @(posedge clk);
        #1;
        push_op(1'b0, 16'h0001, 16'h0001);
        run_ops(50);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; req = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
`ifdef CLA_SCHED_SUB_EN
        sub = 2'b00;
`endif
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie straight out of reset: requester 0 first, then requester 1.
        push_op(1'b0, 16'h1234, 16'h1111);
        push_op(1'b1, 16'h00FF, 16'h0001);
        run_ops(50);

        push_op(1'b0, 16'hFFFF, 16'h0001);
        run_ops(50);

        withdraw_test();
        reset_mid_run();

        for (int i = 0; i < 300; i++) begin
            push_op(1'b0, rand_op(), rand_op());
            push_op(1'b1, rand_op(), rand_op());
        end
        run_ops(300 * 2 * (NIB + 2) + 100);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 2))
                0:       push_op(1'b0, rand_op(), rand_op());
                1:       push_op(1'b1, rand_op(), rand_op());
                default: begin
                    push_op(1'b0, rand_op(), rand_op());
                    push_op(1'b1, rand_op(), rand_op());
                end
            endcase
            run_ops(50);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

`ifdef CLA_SCHED_SUB_EN
        sub = 2'b01;
        push_op(1'b0, 16'h0005, 16'h0007);
        push_op(1'b0, 16'h0007, 16'h0005);
        push_op(1'b1, 16'h0007, 16'h0005);
        run_ops(100);
        for (int i = 0; i < 50; i++) begin
            push_op(1'b0, rand_op(), rand_op());
            push_op(1'b1, rand_op(), rand_op());
        end
        sub = 2'($urandom_range(0, 3));
        run_ops(50 * 2 * (NIB + 2) + 100);
        sub = 2'b00;
`endif

        check("drain", due_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
